// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and address-width helper for the data memory slave
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, BUSY, RESP} state_e;

    // Word-index width; never below 1 so a single-word memory still has an index bit
    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with 4-lane byte write enable and registered read port
//   clk_i   clock
//   we_i    write strobe, qualified per lane by be_i
//   be_i    byte-lane enables
//   re_i    read strobe; loads rdata_o at the clock edge
//   addr_i  word index
//   wdata_i write data
//   rdata_o registered read data, held until the next read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < BE_W; n++)
            if (we_i && be_i[n]) mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_slave.sv
// data_mem_slave: word data memory answering the core's req/gnt/rvalid protocol with wait states
//   clk_i, rst_i        clock, synchronous active-high reset
//   data_req_i          request, held until the rvalid cycle
//   data_we_i           1 = write, 0 = read
//   data_be_i           write byte enables
//   data_addr_i         byte address, [1:0] ignored
//   data_wdata_i        lane-replicated write data
//   data_gnt_o          request accepted this cycle
//   data_rvalid_o       one-cycle response strobe
//   data_rdata_o        read data during rvalid, 0 otherwise
//   data_err_o          out-of-range flag during rvalid
module data_mem_slave
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int GNT_DELAY   = 0,
    parameter int RSP_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [WORD_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [WORD_W-1:0] data_rdata_o,
    output logic              data_err_o
);
    localparam int ADDR_W = clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              we_q, err_q;
    logic              grant;
    logic              in_range;
    logic              resp;
    logic [WORD_W-1:0] arr_rdata;
    logic              unused_addr;

    assign unused_addr = ^data_addr_i[1:0];
    assign in_range    = data_addr_i[31:2] < 30'(DEPTH_WORDS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE:
                if (data_req_i) begin
                    if (GNT_DELAY == 0) grant = 1'b1;
                    else begin
                        cnt_d   = 16'(GNT_DELAY - 1);
                        state_d = WAIT_GNT;
                    end
                end
            WAIT_GNT:
                if (!data_req_i) state_d = IDLE;
                else if (cnt_q == 16'd0) grant = 1'b1;
                else cnt_d = cnt_q - 16'd1;
            BUSY:
                if (cnt_q == 16'd0) state_d = RESP;
                else cnt_d = cnt_q - 16'd1;
            default: state_d = IDLE;
        endcase
        if (grant) begin
            state_d = (RSP_LATENCY == 1) ? RESP : BUSY;
            cnt_d   = 16'(RSP_LATENCY - 2);
        end
    end

    // Suppress grant while reset is asserted so no write can slip in during reset
    assign data_gnt_o = grant && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (data_gnt_o) begin
                we_q  <= data_we_i;
                err_q <= !in_range;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(ADDR_W)) u_array (
        .clk_i   (clk_i),
        .we_i    (data_gnt_o && data_we_i && in_range),
        .be_i    (data_be_i),
        .re_i    (data_gnt_o && !data_we_i),
        .addr_i  (data_addr_i[ADDR_W+1:2]),
        .wdata_i (data_wdata_i),
        .rdata_o (arr_rdata)
    );

    assign resp          = state_q == RESP;
    assign data_rvalid_o = resp;
    assign data_err_o    = resp && err_q;
    assign data_rdata_o  = (resp && !we_q && !err_q) ? arr_rdata : '0;
endmodule
